// File: rtl/l1_i_pkg.sv
// Shared widths, set count and FSM state type for the L1 instruction-cache controller.
package l1_i_pkg;

  localparam int TNUM   = 21;
  localparam int INUM   = 26 - TNUM;
  localparam int TNUM_2 = 18;
  localparam int INUM_2 = 26 - TNUM_2;
  localparam int LNUM   = TNUM + INUM;
  localparam int NSETS  = 2 ** INUM;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MISS   = 2'd1,
    REFILL = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/l1_i_tag_array.sv
// Tag, valid and LRU storage for the 2-way L1 instruction cache.
// Combinational read by index, write by (index, way), whole-array clear of valid and LRU.
module l1_i_tag_array
  import l1_i_pkg::*;
(
  input  logic            clk,
  input  logic            nrst,
  input  logic [INUM-1:0] rd_index,
  output logic [TNUM-1:0] rd_tag0,
  output logic [TNUM-1:0] rd_tag1,
  output logic            rd_valid0,
  output logic            rd_valid1,
  output logic            rd_lru,
  input  logic            wr_en,
  input  logic [INUM-1:0] wr_index,
  input  logic            wr_way,
  input  logic [TNUM-1:0] wr_tag,
  input  logic            lru_en,
  input  logic [INUM-1:0] lru_index,
  input  logic            lru_val,
  input  logic            clr
);

  logic [TNUM-1:0]  tag0_r [NSETS];
  logic [TNUM-1:0]  tag1_r [NSETS];
  logic [NSETS-1:0] valid0_r;
  logic [NSETS-1:0] valid1_r;
  logic [NSETS-1:0] lru_r;

  assign rd_tag0   = tag0_r[rd_index];
  assign rd_tag1   = tag1_r[rd_index];
  assign rd_valid0 = valid0_r[rd_index];
  assign rd_valid1 = valid1_r[rd_index];
  assign rd_lru    = lru_r[rd_index];

  // Valid and LRU bits: reset and clear take priority over fill/touch updates
  always_ff @(posedge clk) begin
    if (!nrst) begin
      valid0_r <= '0;
      valid1_r <= '0;
      lru_r    <= '0;
    end else if (clr) begin
      valid0_r <= '0;
      valid1_r <= '0;
      lru_r    <= '0;
    end else begin
      if (wr_en) begin
        if (wr_way) begin
          valid1_r[wr_index] <= 1'b1;
        end else begin
          valid0_r[wr_index] <= 1'b1;
        end
      end
      if (lru_en) begin
        lru_r[lru_index] <= lru_val;
      end
    end
  end

  // Tag storage needs no reset: an entry is only trusted behind its valid bit
  always_ff @(posedge clk) begin
    if (wr_en && !wr_way) begin
      tag0_r[wr_index] <= wr_tag;
    end
    if (wr_en && wr_way) begin
      tag1_r[wr_index] <= wr_tag;
    end
  end

endmodule

// File: rtl/l1_i_controller.sv
// L1 instruction-cache controller: hit/miss detection, victim choice and miss handshake to L2.
// Optional flush-on-rising-edge support is compiled in with macro L1_I_FLUSH_EN.
module l1_i_controller
  import l1_i_pkg::*;
(
  input  logic              clk,
  input  logic              nrst,
  input  logic [TNUM-1:0]   tag_C_L1,
  input  logic [INUM-1:0]   index_C_L1,
  input  logic              read_C_L1,
  input  logic              flush,
  input  logic              ready_L2_L1,
  output logic              stall,
  output logic              refill,
  output logic              way,
  output logic              read_L1_L2,
  output logic [INUM_2-1:0] index_L1_L2,
  output logic [TNUM_2-1:0] tag_L1_L2
);

  state_t          state_r;
  state_t          state_nxt;
  logic [LNUM-1:0] req_line_r;
  logic            victim_r;

  logic [TNUM-1:0] rd_tag0_s;
  logic [TNUM-1:0] rd_tag1_s;
  logic            rd_valid0_s;
  logic            rd_valid1_s;
  logic            rd_lru_s;
  logic            hit0_s;
  logic            hit1_s;
  logic            hit_s;
  logic            hit_way_s;
  logic            victim_s;
  logic            miss_s;
  logic            clr_s;
  logic            lru_en_s;
  logic [INUM-1:0] lru_index_s;
  logic            lru_val_s;
  logic [TNUM-1:0] req_tag_s;
  logic [INUM-1:0] req_index_s;

  assign req_tag_s   = req_line_r[LNUM-1:INUM];
  assign req_index_s = req_line_r[INUM-1:0];
  assign tag_L1_L2   = req_line_r[LNUM-1:INUM_2];
  assign index_L1_L2 = req_line_r[INUM_2-1:0];

`ifdef L1_I_FLUSH_EN
  logic flush_q_r;
  logic flush_pend_r;
  logic flush_edge_s;

  assign flush_edge_s = flush & ~flush_q_r;
  assign clr_s        = (state_r == IDLE) & (flush_edge_s | flush_pend_r);

  // Flush edge history; an edge outside IDLE waits until the FSM returns there
  always_ff @(posedge clk) begin
    if (!nrst) begin
      flush_q_r    <= 1'b0;
      flush_pend_r <= 1'b0;
    end else begin
      flush_q_r <= flush;
      if (state_r != IDLE && flush_edge_s) begin
        flush_pend_r <= 1'b1;
      end else if (state_r == IDLE) begin
        flush_pend_r <= 1'b0;
      end
    end
  end
`else
  logic unused_flush_s;

  assign unused_flush_s = flush;
  assign clr_s          = 1'b0;
`endif

  // A clear in progress masks hits so the access is retried against the emptied array
  assign hit0_s    = read_C_L1 & ~clr_s & rd_valid0_s & (rd_tag0_s == tag_C_L1);
  assign hit1_s    = read_C_L1 & ~clr_s & rd_valid1_s & (rd_tag1_s == tag_C_L1);
  assign hit_s     = hit0_s | hit1_s;
  assign hit_way_s = hit1_s & ~hit0_s;

  // Victim: first invalid way, else the LRU way; after a clear every way is free
  always_comb begin
    victim_s = 1'b0;
    if (clr_s || !rd_valid0_s) begin
      victim_s = 1'b0;
    end else if (!rd_valid1_s) begin
      victim_s = 1'b1;
    end else begin
      victim_s = rd_lru_s;
    end
  end

  l1_i_tag_array u_tag_array (
    .clk       (clk),
    .nrst      (nrst),
    .rd_index  (index_C_L1),
    .rd_tag0   (rd_tag0_s),
    .rd_tag1   (rd_tag1_s),
    .rd_valid0 (rd_valid0_s),
    .rd_valid1 (rd_valid1_s),
    .rd_lru    (rd_lru_s),
    .wr_en     (state_r == REFILL),
    .wr_index  (req_index_s),
    .wr_way    (victim_r),
    .wr_tag    (req_tag_s),
    .lru_en    (lru_en_s),
    .lru_index (lru_index_s),
    .lru_val   (lru_val_s),
    .clr       (clr_s)
  );

  // Next-state and output decode
  always_comb begin
    state_nxt   = state_r;
    stall       = 1'b0;
    refill      = 1'b0;
    read_L1_L2  = 1'b0;
    way         = victim_r;
    miss_s      = 1'b0;
    lru_en_s    = 1'b0;
    lru_index_s = index_C_L1;
    lru_val_s   = 1'b0;
    case (state_r)
      IDLE: begin
        way = hit_way_s;
        if (hit_s) begin
          lru_en_s  = 1'b1;
          lru_val_s = ~hit_way_s;
          state_nxt = IDLE;
        end else if (read_C_L1) begin
          stall     = 1'b1;
          miss_s    = 1'b1;
          state_nxt = MISS;
        end else begin
          state_nxt = IDLE;
        end
      end
      MISS: begin
        stall      = 1'b1;
        read_L1_L2 = 1'b1;
        if (ready_L2_L1) begin
          state_nxt = REFILL;
        end else begin
          state_nxt = MISS;
        end
      end
      REFILL: begin
        stall       = 1'b1;
        refill      = 1'b1;
        lru_en_s    = 1'b1;
        lru_index_s = req_index_s;
        lru_val_s   = ~victim_r;
        state_nxt   = DONE;
      end
      DONE: begin
        stall     = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register plus miss request/victim capture
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_r    <= IDLE;
      req_line_r <= '0;
      victim_r   <= 1'b0;
    end else begin
      state_r <= state_nxt;
      if (miss_s) begin
        req_line_r <= {tag_C_L1, index_C_L1};
        victim_r   <= victim_s;
      end
    end
  end

endmodule

// File: tb/tb_l1_i_controller.sv
// Scoreboard bench for l1_i_controller: fills, hits, LRU replacement, flush and reset abort.
module tb_l1_i_controller;

  logic        clk = 1'b0;
  logic        nrst;
  logic [20:0] tag_C_L1;
  logic [4:0]  index_C_L1;
  logic        read_C_L1;
  logic        flush;
  logic        ready_L2_L1;
  logic        stall;
  logic        refill;
  logic        way;
  logic        read_L1_L2;
  logic [7:0]  index_L1_L2;
  logic [17:0] tag_L1_L2;

  typedef struct packed {
    logic        way;
    logic [17:0] tag2;
    logic [7:0]  idx2;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  l1_i_controller dut (
    .clk         (clk),
    .nrst        (nrst),
    .tag_C_L1    (tag_C_L1),
    .index_C_L1  (index_C_L1),
    .read_C_L1   (read_C_L1),
    .flush       (flush),
    .ready_L2_L1 (ready_L2_L1),
    .stall       (stall),
    .refill      (refill),
    .way         (way),
    .read_L1_L2  (read_L1_L2),
    .index_L1_L2 (index_L1_L2),
    .tag_L1_L2   (tag_L1_L2)
  );

  function automatic logic [20:0] mk_tag(input int p, input int i);
    return {8'(p), 8'hA5, 5'(i)};
  endfunction

  task automatic run_miss(input logic [20:0] t, input logic [4:0] i, input logic exp_way, input int lat);
    exp_t e;
    exp_t got;
    @(negedge clk);
    tag_C_L1 = t; index_C_L1 = i; read_C_L1 = 1'b1;
    e.way = exp_way; e.tag2 = t[20:3]; e.idx2 = {t[2:0], i};
    exp_q.push_back(e);
    #1;
    checks++;
    if ({stall, refill, read_L1_L2} !== 3'b100) begin
      errors++; $display("FAIL miss_c0 idx=%0d stall/refill/rd got=%b exp=100", i, {stall, refill, read_L1_L2});
    end
    for (int n = 1; n <= lat; n++) begin
      @(negedge clk);
      ready_L2_L1 = (n == lat);
      #1;
      checks++;
      if ({stall, refill, read_L1_L2} !== 3'b101) begin
        errors++; $display("FAIL miss_wait idx=%0d cyc=%0d got=%b exp=101", i, n, {stall, refill, read_L1_L2});
      end
    end
    @(negedge clk);
    ready_L2_L1 = 1'b0;
    #1;
    checks++;
    if ({stall, refill, read_L1_L2} !== 3'b110) begin
      errors++; $display("FAIL refill idx=%0d got=%b exp=110", i, {stall, refill, read_L1_L2});
    end
    if (refill === 1'b1 && exp_q.size() > 0) begin
      got = exp_q.pop_front();
      checks++;
      if ({way, tag_L1_L2, index_L1_L2} !== got) begin
        errors++; $display("FAIL refill_sb idx=%0d got way=%0d tag=%h ix=%h exp way=%0d tag=%h ix=%h",
                           i, way, tag_L1_L2, index_L1_L2, got.way, got.tag2, got.idx2);
      end
    end
    @(negedge clk); #1;
    checks++;
    if ({stall, refill, read_L1_L2} !== 3'b100) begin
      errors++; $display("FAIL done idx=%0d got=%b exp=100", i, {stall, refill, read_L1_L2});
    end
    @(negedge clk); #1;
    checks++;
    if ({stall, refill, read_L1_L2, way} !== {3'b000, exp_way}) begin
      errors++; $display("FAIL retry_hit idx=%0d got=%b exp=%b", i, {stall, refill, read_L1_L2, way}, {3'b000, exp_way});
    end
  endtask

  task automatic run_hit(input logic [20:0] t, input logic [4:0] i, input logic exp_way);
    exp_t e;
    exp_t got;
    @(negedge clk);
    tag_C_L1 = t; index_C_L1 = i; read_C_L1 = 1'b1;
    e.way = exp_way; e.tag2 = '0; e.idx2 = '0;
    exp_q.push_back(e);
    #1;
    checks++;
    if ({stall, refill, read_L1_L2} !== 3'b000) begin
      errors++; $display("FAIL hit_stall idx=%0d got=%b exp=000", i, {stall, refill, read_L1_L2});
    end
    if (stall === 1'b0 && exp_q.size() > 0) begin
      got = exp_q.pop_front();
      checks++;
      if (way !== got.way) begin
        errors++; $display("FAIL hit_way idx=%0d got=%0d exp=%0d", i, way, got.way);
      end
    end
  endtask

  task automatic test_reset();
    nrst = 1'b0; read_C_L1 = 1'b0; flush = 1'b0; ready_L2_L1 = 1'b0;
    tag_C_L1 = '0; index_C_L1 = '0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({stall, refill, read_L1_L2, way, tag_L1_L2, index_L1_L2} !== 30'd0) begin
      errors++; $display("FAIL reset_outputs got=%h exp=0", {stall, refill, read_L1_L2, way, tag_L1_L2, index_L1_L2});
    end
    nrst = 1'b1;
  endtask

  task automatic test_cold_fill();
    for (int i = 0; i < 32; i++) run_miss(mk_tag(1, i), 5'(i), 1'b0, 4);
  endtask

  task automatic test_fill_way1();
    for (int i = 0; i < 32; i++) run_miss(mk_tag(2, i), 5'(i), 1'b1, 4);
  endtask

  task automatic test_hits();
    for (int i = 0; i < 32; i++) run_hit(mk_tag(1, i), 5'(i), 1'b0);
    for (int i = 0; i < 32; i++) run_hit(mk_tag(2, i), 5'(i), 1'b1);
  endtask

  task automatic test_lru();
    for (int i = 0; i < 32; i++) run_miss(mk_tag(3, i), 5'(i), 1'b0, 4);
    for (int i = 0; i < 32; i++) run_miss(mk_tag(4, i), 5'(i), 1'b1, 4);
  endtask

`ifdef L1_I_FLUSH_EN
  task automatic test_flush();
    @(negedge clk);
    read_C_L1 = 1'b0; flush = 1'b1;
    repeat (2) @(negedge clk);
    run_miss(mk_tag(3, 0), 5'd0, 1'b0, 16);
    for (int i = 1; i < 4; i++) run_miss(mk_tag(3, i), 5'(i), 1'b0, 4);
    run_miss(mk_tag(4, 0), 5'd0, 1'b1, 5);
    run_hit(mk_tag(3, 1), 5'd1, 1'b0);
    run_hit(mk_tag(4, 0), 5'd0, 1'b1);
  endtask
`endif

  task automatic test_reset_mid_miss();
    @(negedge clk);
    tag_C_L1 = mk_tag(5, 7); index_C_L1 = 5'd7; read_C_L1 = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (read_L1_L2 !== 1'b1) begin
      errors++; $display("FAIL mid_miss_req got=%b exp=1", read_L1_L2);
    end
    @(negedge clk);
    nrst = 1'b0; read_C_L1 = 1'b0;
    @(negedge clk); #1;
    checks++;
    if ({stall, refill, read_L1_L2, way, tag_L1_L2, index_L1_L2} !== 30'd0) begin
      errors++; $display("FAIL mid_miss_reset got=%h exp=0", {stall, refill, read_L1_L2, way, tag_L1_L2, index_L1_L2});
    end
    nrst = 1'b1;
    run_miss(mk_tag(1, 0), 5'd0, 1'b0, 4);
  endtask

  initial begin
    test_reset();
    test_cold_fill();
    test_fill_way1();
    test_hits();
    test_lru();
`ifdef L1_I_FLUSH_EN
    test_flush();
`endif
    test_reset_mid_miss();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain left=%0d exp=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/l1_i_controller.md
# l1_i_controller

Control block for the 2-way set-associative L1 instruction cache: tag/valid/LRU bookkeeping, hit/miss detection and the miss handshake toward L2. It sits between the fetch stage (core side, `_C_L1`) and the L2 controller (`_L1_L2` / `_L2_L1`). It holds no instruction data. The L1 data array uses `refill` and `way` as its write strobe and way select.

## Interface
- `TNUM`, 21: L1 tag width, taken from address[31:11].
- `INUM`, `26-TNUM` (=5): L1 index width, taken from address[10:6]; gives 32 sets; line size is 64 B.
- `TNUM_2`, 18: L2 tag width.
- `INUM_2`, `26-TNUM_2` (=8): L2 index width.
- `clk` in 1: single clock, all state on rising edge.
- `nrst` in 1: reset, synchronous, active-low.
- `tag_C_L1` in TNUM: fetch tag.
- `index_C_L1` in INUM: fetch set index.
- `read_C_L1` in 1: fetch request. Core holds the address stable while `stall`=1.
- `flush` in 1: invalidate request.
- `ready_L2_L1` in 1: L2 line-delivered strobe.
- `stall` out 1: core must wait.
- `refill` out 1: one-cycle write strobe for the data array.
- `way` out 1: hit way; during a miss, the victim way.
- `read_L1_L2` out 1: line request to L2.
- `index_L1_L2` out INUM_2: equals `{tag,index}[INUM_2-1:0]` of the missing line.
- `tag_L1_L2` out TNUM_2: equals `{tag,index}[25:INUM_2]` of the missing line.

## Operation
- **Storage:** per set and per way, a tag[TNUM] and a valid bit. Per set, one LRU bit naming the least-recently-used way.
- **Hit check:** hit = `read_C_L1` & valid[w][index] & (tag[w][index] == `tag_C_L1`) for some way w. It is evaluated combinationally in IDLE.
- **FSM states:** IDLE, MISS, REFILL, DONE.
- **IDLE:**
  - On a hit: `way` = hit way, `stall`=0, and LRU[index] is set to the other way.
  - On a miss: `stall`=1 in the same cycle. The request tag/index is latched, the victim is latched, and the FSM goes to MISS.
  - Victim choice: invalid way0, else invalid way1, else LRU[index].
  - With `read_C_L1`=0: `stall`=0.
- **MISS:** `read_L1_L2`=1, `stall`=1. The tag/index outputs are driven from the latched request. The FSM stays until `ready_L2_L1`=1 is sampled, then goes to REFILL.
- **REFILL** (exactly 1 cycle):
  - Outputs: `refill`=1, `stall`=1, `way`=victim.
  - Updates: the victim's tag is written, its valid bit is set, and LRU[index] is set to the other way.
  - Next state: DONE.
- **DONE** (1 cycle): `stall`=1, `refill`=0. Next state is IDLE, where the retried access hits.
- **Flush:**
  - A rising edge of `flush` (registered `flush` compared with the current value) clears all valid and LRU bits.
  - It is acted on only in IDLE. An edge seen in any other state is held pending and applied on return to IDLE.
  - Holding `flush` high has no further effect.
- `tag_L1_L2`/`index_L1_L2` hold their last value outside MISS.

## Timing
- **Reset** (`nrst`=0 at a rising edge):
  - State, valid, LRU, latched request and flush history are cleared.
  - Outputs become `stall`=0, `refill`=0, `read_L1_L2`=0, `way`=0, `tag_L1_L2`=0, `index_L1_L2`=0.
  - Reset in any state aborts the transaction.
- **Hit latency:** 0 cycles (`stall` low in the request cycle).
- **Miss timeline:**
  - C0: IDLE with miss, `stall`=1.
  - C1..Ck: MISS, `read_L1_L2`=1.
  - Ck is the cycle `ready_L2_L1` is sampled high.
  - Ck+1: REFILL.
  - Ck+2: DONE.
  - Ck+3: IDLE, hit, `stall`=0.
- **Required invariant:** a falling edge of `refill` is followed exactly one cycle later by a falling edge of `stall`.
- `ready_L2_L1` outside MISS is ignored.
- `read_L1_L2` drops the cycle after `ready_L2_L1` is sampled.

## Configuration
- **`L1_I_FLUSH_EN` defined:** flush behaves as described above.
- **`L1_I_FLUSH_EN` undefined:** the `flush` port exists but is ignored. Valid bits are cleared only by reset.

## Structure
- **Package `l1_i_pkg`:**
  - state enum {IDLE, MISS, REFILL, DONE};
  - width constants TNUM/INUM/TNUM_2/INUM_2 defaults;
  - the set count `2**INUM`.
- **Sub-module `l1_i_tag_array`:** tag/valid/LRU registers, with read by index, write by (index, way), and flush-clear. The controller FSM lives in the top module.

## Test plan
- **Cold fill way0:**
  - Stimulus: after reset, read 32 addresses with distinct index 0..31; `ready_L2_L1` pulses 4 cycles after each miss.
  - Response: each miss raises `read_L1_L2`, then 1-cycle `refill` with `way`=0, then `stall` falls 1 cycle after `refill` falls.
- **Fill way1:** 32 new tags with the same indices → `refill` with `way`=1 each; `tag_L1_L2`/`index_L1_L2` equal address[31:14]/[13:6].
- **Hits:** re-read all 64 addresses → `stall`=0 every cycle; `way` = 0 for the first 32 and 1 for the second 32; `read_L1_L2` never asserts.
- **LRU replacement:** after the hit sweeps, new tags at indices 0..31 → victim `way`=0; a second set of new tags → victim `way`=1.
- **Flush** (`L1_I_FLUSH_EN`): raise `flush` and hold it → re-reading former hit addresses all miss and refill way0 first. A long L2 latency (≥16 cycles) keeps `stall`=1 and `read_L1_L2`=1 throughout.
- **Reset mid-MISS:** `nrst`=0 while `read_L1_L2`=1 → next cycle all outputs 0; the subsequent read misses.
